// File: rtl/elastic_memory_responder_pkg.sv
// Shared constants and state encoding for the elastic memory responder.
//   DATA_WIDTH    : data word width
//   ADDRESS_WIDTH : request address width
//   LOAD_CYCLE    : default read latency in cycles (accept edge to response valid)
//   mem_state_e   : responder FSM state encoding (MEM_IDLE/MEM_READING/MEM_RESPOND)
package elastic_memory_responder_pkg;

    localparam int unsigned DATA_WIDTH    = 32;
    localparam int unsigned ADDRESS_WIDTH = 16;
    localparam int unsigned LOAD_CYCLE    = 3;

    typedef enum logic [1:0] {
        MEM_IDLE    = 2'd0,
        MEM_READING = 2'd1,
        MEM_RESPOND = 2'd2
    } mem_state_e;

endpackage

// File: rtl/elastic_memory_array.sv
// Single-port synchronous data RAM with a registered read port.
// The RAM contents are never reset; only the read-data register is.
// Ports:
//   clk      : clock, rising edge
//   reset_n  : asynchronous active-low reset (read-data register only)
//   i_we     : write enable, writes i_wdata to i_addr
//   i_re     : read enable, loads o_rdata from i_addr; o_rdata holds otherwise
//   i_addr   : word index
//   i_wdata  : write data
//   o_rdata  : registered read data
module elastic_memory_array #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned DEPTH      = 256,
    parameter int unsigned IDX_W      = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  i_we,
    input  logic                  i_re,
    input  logic [IDX_W-1:0]      i_addr,
    input  logic [DATA_WIDTH-1:0] i_wdata,
    output logic [DATA_WIDTH-1:0] o_rdata
);

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [DATA_WIDTH-1:0] r_rdata;

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_addr] <= i_wdata;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_rdata <= '0;
        end else if (i_re) begin
            r_rdata <= r_mem[i_addr];
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/elastic_memory_responder.sv
// Data-memory responder for elastic PEs. Accepts one load/store at a time on a
// valid/stop request channel; stores complete immediately, loads return data on a
// valid/stop response channel after READ_LATENCY cycles.
// Ports:
//   clk, reset_n       : clock (rising edge), asynchronous active-low reset
//   i_req_valid        : request present
//   o_req_stop         : responder busy, request held off
//   i_req_write        : 1 = store, 0 = load
//   i_req_address      : word address
//   i_req_write_data   : store data
//   o_resp_valid       : load response present
//   i_resp_stop        : consumer cannot take the response
//   o_resp_data        : load data (0 for out-of-range)
//   o_resp_error       : response is for an out-of-range address
module elastic_memory_responder
    import elastic_memory_responder_pkg::*;
#(
    parameter int unsigned DATA_WIDTH    = elastic_memory_responder_pkg::DATA_WIDTH,
    parameter int unsigned ADDRESS_WIDTH = elastic_memory_responder_pkg::ADDRESS_WIDTH,
    parameter int unsigned MEM_DEPTH     = 256,
    parameter int unsigned READ_LATENCY  = elastic_memory_responder_pkg::LOAD_CYCLE
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     i_req_valid,
    output logic                     o_req_stop,
    input  logic                     i_req_write,
    input  logic [ADDRESS_WIDTH-1:0] i_req_address,
    input  logic [DATA_WIDTH-1:0]    i_req_write_data,
    output logic                     o_resp_valid,
    input  logic                     i_resp_stop,
    output logic [DATA_WIDTH-1:0]    o_resp_data,
    output logic                     o_resp_error
);

    localparam int unsigned IDX_W = $clog2(MEM_DEPTH);
    localparam logic [3:0] CNT_LOAD = 4'(READ_LATENCY - 1);
    localparam logic [ADDRESS_WIDTH:0] DEPTH_EXT = (ADDRESS_WIDTH + 1)'(MEM_DEPTH);

    mem_state_e             r_state;
    mem_state_e             w_state_d;
    logic [3:0]             r_count;
    logic [3:0]             w_count_d;
    logic [IDX_W-1:0]       r_addr_idx;
    logic                   r_addr_oor;
    logic                   r_resp_error;

    logic                   w_in_range;
    logic                   w_read_accept;
    logic                   w_we;
    logic                   w_re;
    logic                   w_capture;
    logic                   w_capture_err;
    logic [IDX_W-1:0]       w_ram_addr;
    logic [DATA_WIDTH-1:0]  w_rdata;

    // Zero-extend so the compare is exact for any depth up to 2**ADDRESS_WIDTH.
    assign w_in_range    = ({1'b0, i_req_address} < DEPTH_EXT);
    assign w_read_accept = (r_state == MEM_IDLE) && i_req_valid && !i_req_write;

    always_comb begin
        w_state_d     = r_state;
        w_count_d     = r_count;
        w_we          = 1'b0;
        w_re          = 1'b0;
        w_capture     = 1'b0;
        w_capture_err = r_addr_oor;
        w_ram_addr    = r_addr_idx;
        unique case (r_state)
            MEM_IDLE: begin
                // In IDLE the RAM sees the live request address (write, or a 1-cycle read).
                w_ram_addr = i_req_address[IDX_W-1:0];
                if (i_req_valid) begin
                    if (i_req_write) begin
                        w_we = w_in_range;
                    end else begin
                        w_count_d = CNT_LOAD;
                        if (READ_LATENCY == 1) begin
                            w_state_d     = MEM_RESPOND;
                            w_re          = 1'b1;
                            w_capture     = 1'b1;
                            w_capture_err = !w_in_range;
                        end else begin
                            w_state_d = MEM_READING;
                        end
                    end
                end
            end
            MEM_READING: begin
                if (r_count <= 4'd1) begin
                    w_count_d = 4'd0;
                    w_re      = 1'b1;
                    w_capture = 1'b1;
                    w_state_d = MEM_RESPOND;
                end else begin
                    w_count_d = r_count - 4'd1;
                end
            end
            MEM_RESPOND: begin
                if (!i_resp_stop) begin
                    w_state_d = MEM_IDLE;
                end
            end
            default: begin
                w_state_d = MEM_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= MEM_IDLE;
            r_count      <= 4'd0;
            r_addr_idx   <= '0;
            r_addr_oor   <= 1'b0;
            r_resp_error <= 1'b0;
        end else begin
            r_state <= w_state_d;
            r_count <= w_count_d;
            if (w_read_accept) begin
                r_addr_idx <= i_req_address[IDX_W-1:0];
                r_addr_oor <= !w_in_range;
            end
            if (w_capture) begin
                r_resp_error <= w_capture_err;
            end
        end
    end

    elastic_memory_array #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (MEM_DEPTH),
        .IDX_W      (IDX_W)
    ) u_array (
        .clk     (clk),
        .reset_n (reset_n),
        .i_we    (w_we),
        .i_re    (w_re),
        .i_addr  (w_ram_addr),
        .i_wdata (i_req_write_data),
        .o_rdata (w_rdata)
    );

    assign o_req_stop   = (r_state != MEM_IDLE);
    assign o_resp_valid = (r_state == MEM_RESPOND);
    // The read register still captures the aliased word for an out-of-range read; mask it.
    assign o_resp_data  = r_resp_error ? '0 : w_rdata;
    assign o_resp_error = r_resp_error;

endmodule

// File: tb/tb_elastic_memory_responder.sv
module tb_elastic_memory_responder;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;

    // Instance with READ_LATENCY = 3
    logic        req_valid = 1'b0;
    logic        req_stop;
    logic        req_write = 1'b0;
    logic [15:0] req_address = '0;
    logic [31:0] req_write_data = '0;
    logic        resp_valid;
    logic        resp_stop = 1'b0;
    logic [31:0] resp_data;
    logic        resp_error;

    // Instance with READ_LATENCY = 1
    logic        b_req_valid = 1'b0;
    logic        b_req_stop;
    logic        b_req_write = 1'b0;
    logic [15:0] b_req_address = '0;
    logic [31:0] b_req_write_data = '0;
    logic        b_resp_valid;
    logic        b_resp_stop = 1'b0;
    logic [31:0] b_resp_data;
    logic        b_resp_error;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    elastic_memory_responder #(
        .READ_LATENCY (3)
    ) u_dut3 (
        .clk              (clk),
        .reset_n          (reset_n),
        .i_req_valid      (req_valid),
        .o_req_stop       (req_stop),
        .i_req_write      (req_write),
        .i_req_address    (req_address),
        .i_req_write_data (req_write_data),
        .o_resp_valid     (resp_valid),
        .i_resp_stop      (resp_stop),
        .o_resp_data      (resp_data),
        .o_resp_error     (resp_error)
    );

    elastic_memory_responder #(
        .READ_LATENCY (1)
    ) u_dut1 (
        .clk              (clk),
        .reset_n          (reset_n),
        .i_req_valid      (b_req_valid),
        .o_req_stop       (b_req_stop),
        .i_req_write      (b_req_write),
        .i_req_address    (b_req_address),
        .i_req_write_data (b_req_write_data),
        .o_resp_valid     (b_resp_valid),
        .i_resp_stop      (b_resp_stop),
        .o_resp_data      (b_resp_data),
        .o_resp_error     (b_resp_error)
    );

    typedef struct {
        logic        wr;
        logic [15:0] addr;
        logic [31:0] data;
        logic [31:0] exp_data;
        logic        exp_err;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic do_write(input logic [15:0] addr, input logic [31:0] data);
        @(negedge clk);
        req_valid      = 1'b1;
        req_write      = 1'b1;
        req_address    = addr;
        req_write_data = data;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        req_write = 1'b0;
        check("write_no_resp", {31'b0, resp_valid}, 32'd0);
        check("write_stays_idle", {31'b0, req_stop}, 32'd0);
    endtask

    // Issue a read on the latency-3 instance; resp_stop is low so it is taken immediately.
    task automatic do_read(input logic [15:0] addr, input logic [31:0] exp_data,
                           input logic exp_err);
        int lat;
        lat = 0;
        @(negedge clk);
        req_valid   = 1'b1;
        req_write   = 1'b0;
        req_address = addr;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            if (resp_valid) begin
                lat = k;
                break;
            end
            @(negedge clk);
        end
        check("read_latency", lat, 32'd3);
        check("read_data", resp_data, exp_data);
        check("read_error", {31'b0, resp_error}, {31'b0, exp_err});
        @(negedge clk);
        check("read_taken", {31'b0, resp_valid}, 32'd0);
        check("read_back_idle", {31'b0, req_stop}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        vec_t vecs[12];
        logic [31:0] held;
        logic        seen;
        logic        early;
        logic        drop;
        int          got;
        int          accepts;
        logic [31:0] rd [2];

        vecs[0]  = '{1'b1, 16'h0010, 32'hDEADBEEF, 32'h0, 1'b0};
        vecs[1]  = '{1'b0, 16'h0010, 32'h0, 32'hDEADBEEF, 1'b0};
        vecs[2]  = '{1'b1, 16'h0000, 32'hCAFE0000, 32'h0, 1'b0};
        vecs[3]  = '{1'b1, 16'h0001, 32'h11111111, 32'h0, 1'b0};
        vecs[4]  = '{1'b1, 16'h0002, 32'h22222222, 32'h0, 1'b0};
        vecs[5]  = '{1'b0, 16'h0200, 32'h0, 32'h0, 1'b1};
        vecs[6]  = '{1'b1, 16'h0200, 32'h00000055, 32'h0, 1'b0};
        vecs[7]  = '{1'b0, 16'h0000, 32'h0, 32'hCAFE0000, 1'b0};
        vecs[8]  = '{1'b1, 16'h00FF, 32'hA5A5A5A5, 32'h0, 1'b0};
        vecs[9]  = '{1'b0, 16'h00FF, 32'h0, 32'hA5A5A5A5, 1'b0};
        vecs[10] = '{1'b1, 16'h0110, 32'h00000077, 32'h0, 1'b0};
        vecs[11] = '{1'b0, 16'h0010, 32'h0, 32'hDEADBEEF, 1'b0};

        // Reset state
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        check("rst_req_stop", {31'b0, req_stop}, 32'd0);
        check("rst_resp_valid", {31'b0, resp_valid}, 32'd0);
        check("rst_resp_data", resp_data, 32'd0);
        check("rst_resp_error", {31'b0, resp_error}, 32'd0);

        // Table: writes, reads, out-of-range and aliasing cases
        for (int i = 0; i < 12; i++) begin
            if (vecs[i].wr) do_write(vecs[i].addr, vecs[i].data);
            else            do_read(vecs[i].addr, vecs[i].exp_data, vecs[i].exp_err);
        end

        // Response held under resp_stop for 5 cycles
        resp_stop = 1'b1;
        @(negedge clk);
        req_valid   = 1'b1;
        req_write   = 1'b0;
        req_address = 16'h0010;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        seen = 1'b0;
        for (int k = 0; k < 20; k++) begin
            if (resp_valid) begin
                seen = 1'b1;
                break;
            end
            @(negedge clk);
        end
        check("stall_resp_seen", {31'b0, seen}, 32'd1);
        held = resp_data;
        check("stall_first_data", held, 32'hDEADBEEF);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("stall_valid", {31'b0, resp_valid}, 32'd1);
            check("stall_data", resp_data, 32'hDEADBEEF);
            check("stall_req_stop", {31'b0, req_stop}, 32'd1);
        end
        resp_stop = 1'b0;
        @(negedge clk);
        check("stall_taken", {31'b0, resp_valid}, 32'd0);
        check("stall_idle", {31'b0, req_stop}, 32'd0);

        // req_valid held high across back-to-back reads @1 then @2
        @(negedge clk);
        req_valid   = 1'b1;
        req_write   = 1'b0;
        req_address = 16'h0001;
        @(posedge clk);
        @(negedge clk);
        req_address = 16'h0002;
        got = 0;
        accepts = 0;
        early = 1'b0;
        drop = 1'b0;
        rd[0] = '0;
        rd[1] = '0;
        for (int c = 0; c < 40 && got < 2; c++) begin
            if (drop) begin
                req_valid = 1'b0;
                drop = 1'b0;
            end
            if (resp_valid) begin
                rd[got] = resp_data;
                got++;
            end
            if (!req_stop && req_valid) begin
                if (got == 0) early = 1'b1;
                accepts++;
                drop = 1'b1;
            end
            @(negedge clk);
        end
        req_valid = 1'b0;
        check("b2b_count", got, 32'd2);
        check("b2b_first", rd[0], 32'h11111111);
        check("b2b_second", rd[1], 32'h22222222);
        check("b2b_early_accept", {31'b0, early}, 32'd0);
        check("b2b_accepts", accepts, 32'd1);
        check("b2b_idle", {31'b0, req_stop}, 32'd0);

        // Reset while READING
        @(negedge clk);
        req_valid   = 1'b1;
        req_write   = 1'b0;
        req_address = 16'h0010;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        check("pre_rst_busy", {31'b0, req_stop}, 32'd1);
        reset_n = 1'b0;
        #1;
        check("rst_mid_valid", {31'b0, resp_valid}, 32'd0);
        check("rst_mid_stop", {31'b0, req_stop}, 32'd0);
        check("rst_mid_data", resp_data, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        seen = 1'b0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (resp_valid) seen = 1'b1;
        end
        check("rst_no_stale", {31'b0, seen}, 32'd0);
        do_read(16'h0010, 32'hDEADBEEF, 1'b0);

        // READ_LATENCY=1 instance: write then read-after-write on the next cycle
        @(negedge clk);
        b_req_valid      = 1'b1;
        b_req_write      = 1'b1;
        b_req_address    = 16'h0005;
        b_req_write_data = 32'h00001234;
        @(posedge clk);
        @(negedge clk);
        b_req_write = 1'b0;
        check("l1_write_idle", {31'b0, b_req_stop}, 32'd0);
        @(posedge clk);
        @(negedge clk);
        b_req_valid = 1'b0;
        check("l1_valid", {31'b0, b_resp_valid}, 32'd1);
        check("l1_data", b_resp_data, 32'h00001234);
        check("l1_error", {31'b0, b_resp_error}, 32'd0);
        @(negedge clk);
        check("l1_taken", {31'b0, b_resp_valid}, 32'd0);
        check("l1_idle", {31'b0, b_req_stop}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
